// File: rtl/deframer_if.sv
// Byte stream interface shared by the framed input and the payload output of the deframer.
// The framed side carries no tlast, so the slave modport leaves it out.
interface deframer_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/deframer.sv
// Deframer: strips START/STOP delimiters from an 8-bit byte stream and regenerates tlast
// on the last payload byte.
// Optional escape decoding is enabled by defining DEFRAMER_ESCAPE_EN; this adds an escape
// state and the ESC_BYTE parameter. Without it, ESC_BYTE values are ordinary payload.
module deframer #(
    parameter logic [7:0] START_BYTE = 8'h7D,
    parameter logic [7:0] STOP_BYTE  = 8'h7E
`ifdef DEFRAMER_ESCAPE_EN
    ,
    parameter logic [7:0] ESC_BYTE   = 8'h7F
`endif
) (
    input  logic       aclk,
    input  logic       aresetn,
    deframer_if.slave  target,
    deframer_if.master initiator,
    output logic       frame_error
);

`ifdef DEFRAMER_ESCAPE_EN
    typedef enum logic [1:0] {StHunt, StFirst, StData, StEsc} state_e;
`else
    typedef enum logic [1:0] {StHunt, StFirst, StData} state_e;
`endif

    state_e     state_q, state_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_valid_q, hold_valid_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       err_q, err_d;

    logic       accept;
    logic       is_start;
    logic       is_stop;
    logic       load;
    logic       load_last;
`ifdef DEFRAMER_ESCAPE_EN
    logic       is_esc;
    assign is_esc = (target.tdata == ESC_BYTE);
`endif

    // Every accepted byte yields at most one beat, so accept only when the output slot frees.
    assign target.tready = !out_valid_q || initiator.tready;
    assign accept        = target.tvalid && target.tready;
    assign is_start      = (target.tdata == START_BYTE);
    assign is_stop       = (target.tdata == STOP_BYTE);

    // Frame state machine: decides hold updates and whether the held byte is emitted.
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;
        load_last    = 1'b0;
        err_d        = 1'b0;
        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (is_start) begin
                        state_d = StFirst;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StFirst: begin
                    if (is_start) begin
                        state_d = StFirst;
                    end else if (is_stop) begin
                        // Empty frame: nothing to emit, not an error.
                        state_d = StHunt;
`ifdef DEFRAMER_ESCAPE_EN
                    end else if (is_esc) begin
                        state_d = StEsc;
`endif
                    end else begin
                        hold_data_d  = target.tdata;
                        hold_valid_d = 1'b1;
                        state_d      = StData;
                    end
                end
                StData: begin
                    if (is_start) begin
                        // Truncated packet: close it and begin a new frame.
                        load         = 1'b1;
                        load_last    = 1'b1;
                        err_d        = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = StFirst;
                    end else if (is_stop) begin
                        load         = 1'b1;
                        load_last    = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = StHunt;
`ifdef DEFRAMER_ESCAPE_EN
                    end else if (is_esc) begin
                        state_d = StEsc;
`endif
                    end else begin
                        load        = 1'b1;
                        hold_data_d = target.tdata;
                    end
                end
`ifdef DEFRAMER_ESCAPE_EN
                StEsc: begin
                    // hold_valid_q tells whether the escape came from FIRST or DATA.
                    if (is_start || is_stop) begin
                        err_d        = 1'b1;
                        load         = hold_valid_q;
                        load_last    = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = is_start ? StFirst : StHunt;
                    end else begin
                        load         = hold_valid_q;
                        hold_data_d  = target.tdata ^ 8'h20;
                        hold_valid_d = 1'b1;
                        state_d      = StData;
                    end
                end
`endif
                default: begin
                    state_d      = StHunt;
                    hold_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Output register: loads a beat from the hold, otherwise drains on handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_last_d  = load_last;
        end else if (out_valid_q && initiator.tready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StHunt;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
        end
    end

    assign initiator.tvalid = out_valid_q;
    assign initiator.tdata  = out_data_q;
    assign initiator.tlast  = out_last_q;
    assign frame_error      = err_q;

endmodule

// File: tb/tb_deframer.sv
// Directed testbench for the deframer: drives framed bytes, collects output beats and
// frame_error pulses, and checks them against hand-computed expectations.
module tb_deframer;
    logic aclk;
    logic aresetn;
    logic frame_error;

    deframer_if tgt_if ();
    deframer_if ini_if ();

    deframer u_dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .target      (tgt_if),
        .initiator   (ini_if),
        .frame_error (frame_error)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] beats_q[$];
    int         err_seen = 0;
    int         rdy_mode = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial tgt_if.tlast = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        check("tready_rule", {31'd0, tgt_if.tready}, {31'd0, (!ini_if.tvalid || ini_if.tready)});
        if (aresetn && prev_stall) begin
            check("stall_valid", {31'd0, ini_if.tvalid}, 32'd1);
            check("stall_data", {24'd0, ini_if.tdata}, {24'd0, prev_data});
            check("stall_last", {31'd0, ini_if.tlast}, {31'd0, prev_last});
        end
        if (aresetn && ini_if.tvalid && ini_if.tready) beats_q.push_back({ini_if.tlast, ini_if.tdata});
        if (aresetn && frame_error) err_seen <= err_seen + 1;
        prev_stall <= aresetn && ini_if.tvalid && !ini_if.tready;
        prev_data  <= ini_if.tdata;
        prev_last  <= ini_if.tlast;
    end

    // Downstream ready: always 1 in mode 0, repeating 1,0,0,1 in mode 1.
    initial begin
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        ini_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 1) begin
                ini_if.tready = pat[3 - idx];
                idx = (idx + 1) % 4;
            end else begin
                ini_if.tready = 1'b1;
                idx = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        logic done;
        logic acc;
        done = 1'b0;
        tgt_if.tvalid = 1'b1;
        tgt_if.tdata  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            acc = tgt_if.tvalid && tgt_if.tready;
            @(posedge aclk);
            #1;
            if (acc) done = 1'b1;
        end
        tgt_if.tvalid = 1'b0;
        check("accept_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_present"}, {31'd0, (beats_q.size() != 0)}, 32'd1);
        if (beats_q.size() != 0) begin
            logic [8:0] bt;
            bt = beats_q.pop_front();
            check({tag, "_data"}, {24'd0, bt[7:0]}, {24'd0, d});
            check({tag, "_last"}, {31'd0, bt[8]}, {31'd0, l});
        end
    endtask

    task automatic expect_end(input string tag, input int errs, input int err_base);
        check({tag, "_no_extra_beats"}, beats_q.size(), 32'd0);
        check({tag, "_frame_errors"}, err_seen - err_base, errs);
        beats_q.delete();
    endtask

    initial begin
        int base;
        aresetn       = 1'b0;
        tgt_if.tvalid = 1'b0;
        tgt_if.tdata  = 8'h00;
        #12;
        check("rst_tvalid", {31'd0, ini_if.tvalid}, 32'd0);
        check("rst_tdata", {24'd0, ini_if.tdata}, 32'd0);
        check("rst_tlast", {31'd0, ini_if.tlast}, 32'd0);
        check("rst_frame_error", {31'd0, frame_error}, 32'd0);
        check("rst_tready", {31'd0, tgt_if.tready}, 32'd1);
        #11;
        aresetn = 1'b1;
        idle(2);

        // Basic packet
        base = err_seen;
        send(8'h7D); send(8'h11); send(8'h22); send(8'h33); send(8'h7E);
        idle(5);
        expect_beat("t1_b0", 8'h11, 1'b0);
        expect_beat("t1_b1", 8'h22, 1'b0);
        expect_beat("t1_b2", 8'h33, 1'b1);
        expect_end("t1", 0, base);

        // Empty frame then single-byte frame, back to back
        base = err_seen;
        send(8'h7D); send(8'h7E); send(8'h7D); send(8'hAA); send(8'h7E);
        idle(5);
        expect_beat("t2_b0", 8'hAA, 1'b1);
        expect_end("t2", 0, base);

        // Garbage in HUNT and a START inside a packet
        base = err_seen;
        send(8'h55); send(8'h7D); send(8'h01); send(8'h7D); send(8'h02); send(8'h7E);
        idle(5);
        expect_beat("t3_b0", 8'h01, 1'b1);
        expect_beat("t3_b1", 8'h02, 1'b1);
        expect_end("t3", 2, base);

        // Downstream backpressure
        base = err_seen;
        rdy_mode = 1;
        send(8'h7D); send(8'h10); send(8'h20); send(8'h30); send(8'h7E);
        idle(12);
        rdy_mode = 0;
        idle(2);
        expect_beat("t4_b0", 8'h10, 1'b0);
        expect_beat("t4_b1", 8'h20, 1'b0);
        expect_beat("t4_b2", 8'h30, 1'b1);
        expect_end("t4", 0, base);

        // Reset mid-packet: 44 already out, 55 dropped
        base = err_seen;
        send(8'h7D); send(8'h44); send(8'h55);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check("t5_rst_tvalid", {31'd0, ini_if.tvalid}, 32'd0);
        check("t5_rst_tdata", {24'd0, ini_if.tdata}, 32'd0);
        check("t5_rst_tlast", {31'd0, ini_if.tlast}, 32'd0);
        check("t5_rst_frame_error", {31'd0, frame_error}, 32'd0);
        #10;
        aresetn = 1'b1;
        idle(2);
        send(8'h7D); send(8'h66); send(8'h7E);
        idle(5);
        expect_beat("t5_b0", 8'h44, 1'b0);
        expect_beat("t5_b1", 8'h66, 1'b1);
        expect_end("t5", 0, base);

`ifdef DEFRAMER_ESCAPE_EN
        // Escaped payload
        base = err_seen;
        send(8'h7D); send(8'h7F); send(8'h5E); send(8'h7F); send(8'h5D); send(8'h7E);
        idle(5);
        expect_beat("t6_b0", 8'h7E, 1'b0);
        expect_beat("t6_b1", 8'h7D, 1'b1);
        expect_end("t6", 0, base);

        // STOP right after escape in an empty frame, then garbage proves HUNT
        base = err_seen;
        send(8'h7D); send(8'h7F); send(8'h7E);
        idle(4);
        expect_end("t7", 1, base);
        base = err_seen;
        send(8'h33);
        idle(4);
        expect_end("t7_hunt", 1, base);
`else
        // ESC byte is plain payload
        base = err_seen;
        send(8'h7D); send(8'h7F); send(8'h5E); send(8'h7E);
        idle(5);
        expect_beat("t6_b0", 8'h7F, 1'b0);
        expect_beat("t6_b1", 8'h5E, 1'b1);
        expect_end("t6", 0, base);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
